// File: rtl/frame_draw_scheduler_pkg.sv
// draw_sched_pkg: shared states, default geometry and client indices for the frame draw scheduler.
package draw_sched_pkg;
    typedef enum logic [1:0] {IDLE, START, RUN, NEXT} state_e;
    localparam int DEF_TIMEOUT_CYCLES = 20000;
    localparam int DEF_X_W = 8;
    localparam int DEF_Y_W = 7;
    localparam int MAP_CLIENT = 0;
    localparam int PLAYER_CLIENT = 1;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/frame_draw_scheduler_if.sv
// frame_draw_scheduler_if: draw-client side and ROM/VGA side buses owned by the scheduler.
interface frame_draw_scheduler_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W = 16,
    parameter int RGB_W = 24,
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic [NUM_CLIENTS-1:0] client_start;
    logic [NUM_CLIENTS-1:0] client_done;
    logic [NUM_CLIENTS-1:0] client_plot;
    logic [NUM_CLIENTS*ADDR_W-1:0] client_rom_addr;
    logic [NUM_CLIENTS*X_W-1:0] client_x;
    logic [NUM_CLIENTS*Y_W-1:0] client_y;
    logic [NUM_CLIENTS*RGB_W-1:0] client_rgb;
    logic [ADDR_W-1:0] rom_address;
    logic vga_plot;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [RGB_W-1:0] vga_rgb;
    modport master (
        output client_start, rom_address, vga_plot, vga_x, vga_y, vga_rgb,
        input client_done, client_plot, client_rom_addr, client_x, client_y, client_rgb
    );
    modport slave (
        input client_start, rom_address, vga_plot, vga_x, vga_y, vga_rgb,
        output client_done, client_plot, client_rom_addr, client_x, client_y, client_rgb
    );
endinterface

// File: rtl/frame_draw_scheduler_finder.sv
// next_client_finder: lowest enabled client index strictly above cur (cur = -1 searches from 0).
module next_client_finder #(
    parameter int N = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]       en,
    input  logic signed [IDX_W:0] cur,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en[i] && (i > int'(cur))) begin
                idx = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame sequencer granting the ROM/VGA buses to enabled draw clients in index order.
module frame_draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W = 16,
    parameter int RGB_W = 24,
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [NUM_CLIENTS-1:0]        client_en,
    frame_draw_scheduler_if.master        bus,
    output logic                          busy,
    output logic [idx_w(NUM_CLIENTS)-1:0] active_client,
    output logic                          frame_overrun,
    output logic                          timeout_flag,
    output logic [7:0]                    overrun_count
);
    localparam int IW = idx_w(NUM_CLIENTS);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    state_e state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] en_snap_q, en_snap_d, start_q, start_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic overrun_q, overrun_d, timeout_q, timeout_d;
    logic [7:0] ocnt_q, ocnt_d;
    logic [NUM_CLIENTS-1:0] find_en;
    logic signed [IW:0] find_cur;
    logic [IW-1:0] find_idx;
    logic find_valid, run;
    // IDLE searches the live enables from -1; NEXT searches the snapshot above the grant.
    assign find_en = (state_q == IDLE) ? client_en : en_snap_q;
    assign find_cur = (state_q == IDLE) ? '1 : {1'b0, grant_q};
    next_client_finder #(.N(NUM_CLIENTS), .IDX_W(IW)) u_finder (
        .en(find_en),
        .cur(find_cur),
        .idx(find_idx),
        .valid(find_valid)
    );
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        en_snap_d = en_snap_q;
        wd_d = wd_q;
        start_d = '0;
        timeout_d = 1'b0;
        overrun_d = frame_tick && (state_q != IDLE);
        ocnt_d = (overrun_d && ocnt_q != 8'hff) ? ocnt_q + 8'd1 : ocnt_q;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    en_snap_d = client_en;
                    if (find_valid) begin
                        grant_d = find_idx;
                        start_d = NUM_CLIENTS'(1) << find_idx;
                        state_d = START;
                    end
                end
            end
            START: begin
                wd_d = '0;
                state_d = RUN;
            end
            RUN: begin
                wd_d = wd_q + WD_W'(1);
                // done has priority over an expiring watchdog in the same cycle
                if (bus.client_done[grant_q]) state_d = NEXT;
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (find_valid) begin
                    grant_d = find_idx;
                    start_d = NUM_CLIENTS'(1) << find_idx;
                    state_d = START;
                end else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            en_snap_q <= '0;
            wd_q <= '0;
            start_q <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            ocnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            en_snap_q <= en_snap_d;
            wd_q <= wd_d;
            start_q <= start_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            ocnt_q <= ocnt_d;
        end
    end
    assign run = (state_q == RUN);
    assign bus.client_start = start_q;
    assign bus.vga_plot = run & bus.client_plot[grant_q];
    assign bus.rom_address = run ? bus.client_rom_addr[grant_q*ADDR_W +: ADDR_W] : '0;
    assign bus.vga_x = bus.client_x[grant_q*X_W +: X_W];
    assign bus.vga_y = bus.client_y[grant_q*Y_W +: Y_W];
    assign bus.vga_rgb = bus.client_rgb[grant_q*RGB_W +: RGB_W];
    assign busy = (state_q != IDLE);
    assign active_client = grant_q;
    assign frame_overrun = overrun_q;
    assign timeout_flag = timeout_q;
    assign overrun_count = ocnt_q;
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: directed frames with a cycle-stamped event scoreboard for starts, timeouts and overruns.
module tb_frame_draw_scheduler;
    import draw_sched_pkg::*;
    localparam int N = 4;
    localparam int T = 20000;
    typedef struct {int kind; int val; int cyc;} evt_t;
    logic clk = 1'b0;
    logic reset, frame_tick;
    logic [N-1:0] client_en;
    logic busy, frame_overrun, timeout_flag;
    logic [1:0] active_client;
    logic [7:0] overrun_count;
    int cyc = 0, checks = 0, errors = 0, ocnt = 0;
    evt_t exp_q[$];
    frame_draw_scheduler_if #(.NUM_CLIENTS(N)) bus ();
    frame_draw_scheduler #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .client_en(client_en),
        .bus(bus),
        .busy(busy),
        .active_client(active_client),
        .frame_overrun(frame_overrun),
        .timeout_flag(timeout_flag),
        .overrun_count(overrun_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask
    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask
    task automatic pulse_done(input int i, input int c);
        wait_until(c);
        bus.client_done[i] = 1'b1;
        step();
        bus.client_done[i] = 1'b0;
    endtask
    task automatic push(input int k, input int v, input int c);
        exp_q.push_back('{k, v, c});
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask
    task automatic expect_evt(input int k, input int v);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d val %0d at cycle %0d, required no event", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d val %0d cycle %0d, required kind %0d val %0d cycle %0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask
    // kinds: 0 = client_start vector, 1 = timeout_flag, 2 = frame_overrun with overrun_count
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.client_start != '0) expect_evt(0, int'(bus.client_start));
            if (timeout_flag) expect_evt(1, 0);
            if (frame_overrun) expect_evt(2, int'(overrun_count));
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end
    initial begin
        int t;
        reset = 1'b1;
        frame_tick = 1'b0;
        client_en = '0;
        bus.client_done = '0;
        bus.client_plot = '0;
        bus.client_rom_addr = '0;
        bus.client_x = '0;
        bus.client_y = '0;
        bus.client_rgb = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_start", bus.client_start, 0);
        chk("rst_plot", bus.vga_plot, 0);
        chk("rst_addr", bus.rom_address, 0);
        chk("rst_overrun", frame_overrun, 0);
        chk("rst_timeout", timeout_flag, 0);
        chk("rst_count", overrun_count, 0);
        chk("rst_active", active_client, 0);
        reset = 1'b0;
        step();
        // two clients, enable change mid-frame ignored, foreign done ignored
        client_en = 4'b0011;
        t = cyc;
        push(0, 1, t + 1);
        push(0, 2, t + 54);
        tick();
        client_en = 4'b1111;
        chk("s1_busy_start", busy, 1);
        wait_until(t + 2);
        chk("s1_active0", active_client, MAP_CLIENT);
        pulse_done(1, t + 10);
        pulse_done(0, t + 52);
        wait_until(t + 56);
        bus.client_rom_addr = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
        bus.client_x = {8'd40, 8'd30, 8'd33, 8'd9};
        bus.client_plot = 4'b0001;
        #1;
        chk("s1_active1", active_client, PLAYER_CLIENT);
        chk("s1_mux_plot0", bus.vga_plot, 0);
        chk("s1_mux_addr", bus.rom_address, 16'hBEEF);
        chk("s1_mux_x", bus.vga_x, 33);
        bus.client_plot = 4'b0011;
        #1;
        chk("s1_mux_plot1", bus.vga_plot, 1);
        pulse_done(1, t + 65);
        chk("s1_busy_d1p1", busy, 1);
        step();
        chk("s1_busy_d1p2", busy, 0);
        chk("s1_idle_plot", bus.vga_plot, 0);
        chk("s1_idle_addr", bus.rom_address, 0);
        bus.client_plot = '0;
        bus.client_rom_addr = '0;
        // client2 never finishes: watchdog abort
        client_en = 4'b0101;
        t = cyc;
        push(0, 1, t + 1);
        push(0, 4, t + 9);
        push(1, 0, t + 20010);
        tick();
        pulse_done(0, t + 7);
        wait_until(t + 20011);
        chk("s2_idle_after_timeout", busy, 0);
        // next frame restarts client0; done lands on the expiry cycle and wins
        t = cyc;
        push(0, 1, t + 1);
        push(0, 4, t + 4);
        tick();
        pulse_done(0, t + 2);
        pulse_done(2, t + 5 + T - 1);
        chk("s2_done_wins_flag", timeout_flag, 0);
        chk("s2_done_wins_busy", busy, 1);
        step();
        chk("s2_done_wins_idle", busy, 0);
        // ticks every 100 cycles against a 250-cycle client
        client_en = 4'b0001;
        for (int f = 0; f < 2; f++) begin
            t = cyc;
            push(0, 1, t + 1);
            tick();
            wait_until(t + 100);
            ocnt++;
            push(2, ocnt, t + 101);
            tick();
            wait_until(t + 200);
            ocnt++;
            push(2, ocnt, t + 201);
            tick();
            pulse_done(0, t + 252);
            wait_until(t + 300);
        end
        chk("s3_count", overrun_count, ocnt);
        // continuous ticks while busy drive the counter into saturation
        t = cyc;
        push(0, 1, t + 1);
        frame_tick = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            ocnt = (ocnt < 255) ? ocnt + 1 : 255;
            push(2, ocnt, t + 2 + i);
            step();
        end
        frame_tick = 1'b0;
        chk("s3_saturated", overrun_count, 255);
        pulse_done(0, t + 305);
        wait_until(t + 308);
        // reset mid-RUN together with a tick
        t = cyc;
        push(0, 1, t + 1);
        tick();
        bus.client_plot = 4'b0001;
        bus.client_rom_addr = {48'h0, 16'h1234};
        wait_until(t + 5);
        reset = 1'b1;
        frame_tick = 1'b1;
        step();
        reset = 1'b0;
        frame_tick = 1'b0;
        ocnt = 0;
        chk("s4_busy", busy, 0);
        chk("s4_start", bus.client_start, 0);
        chk("s4_plot", bus.vga_plot, 0);
        chk("s4_addr", bus.rom_address, 0);
        chk("s4_overrun", frame_overrun, 0);
        chk("s4_timeout", timeout_flag, 0);
        chk("s4_count", overrun_count, 0);
        repeat (20) step();
        chk("s4_still_idle", busy, 0);
        t = cyc;
        push(0, 1, t + 1);
        tick();
        pulse_done(0, t + 3);
        wait_until(t + 6);
        bus.client_plot = '0;
        bus.client_rom_addr = '0;
        // empty frame
        client_en = '0;
        tick();
        chk("s5_busy_t1", busy, 0);
        step();
        chk("s5_busy_t2", busy, 0);
        repeat (5) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
